// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// lookahead group size and the step-counter width helper.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned LA_GROUP = 4;

    // Smallest r with 2**r >= value; sizes the counter for clog2(WIDTH+1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle of the sequential restoring divider.
interface seq_restoring_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/borrow_lookahead_subtractor.sv
// diff = a - b - bin with borrow lookahead inside 4-bit groups, group borrows rippled.
module borrow_lookahead_subtractor
    import divider_pkg::*;
#(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout
);
    localparam int unsigned NG = (N + LA_GROUP - 1) / LA_GROUP;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] g;
    logic [N-1:0] p;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Each bit's borrow is a sum of products of its group's g/p and the group borrow-in.
    always_comb begin
        logic carry;
        logic prev;
        logic pp;
        logic term;
        int   base;
        diff  = '0;
        carry = bin;
        prev  = 1'b0;
        pp    = 1'b0;
        term  = 1'b0;
        base  = 0;
        for (int grp = 0; grp < int'(NG); grp++) begin
            base = grp * int'(LA_GROUP);
            prev = carry;
            for (int j = 0; j < int'(LA_GROUP); j++) begin
                if (base + j < int'(N)) begin
                    term = 1'b0;
                    pp   = 1'b1;
                    for (int k = j; k >= 0; k--) begin
                        term = term | (g[IW'(base + k)] & pp);
                        pp   = pp & p[IW'(base + k)];
                    end
                    term = term | (carry & pp);
                    diff[IW'(base + j)] = a[IW'(base + j)] ^ b[IW'(base + j)] ^ prev;
                    prev = term;
                end
            end
            carry = prev;
        end
        bout = carry;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Define DIVIDER_DBZ_EN to short-circuit zero divisors and report div_by_zero.
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_restoring_divider_if.slave bus
);
    localparam int unsigned CW = clog2(WIDTH + 1);
    localparam int unsigned AW = WIDTH + 1;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [AW-1:0]    acc, acc_n;
    logic [WIDTH-1:0] work, work_n;
    logic [WIDTH-1:0] dvs, dvs_n;
    logic [WIDTH-1:0] quot, quot_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic             busy, busy_n;
    logic             done, done_n;
`ifdef DIVIDER_DBZ_EN
    logic             dbz, dbz_n;
`endif

    logic [AW-1:0]    shifted_c;
    logic [AW-1:0]    trial_c;
    logic             borrow_c;

    // Partial remainder shifted left with the next dividend bit from the work register.
    assign shifted_c = AW'({acc, work[WIDTH-1]});

    borrow_lookahead_subtractor #(.N(AW)) u_sub (
        .a    (shifted_c),
        .b    ({1'b0, dvs}),
        .bin  (1'b0),
        .diff (trial_c),
        .bout (borrow_c)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        work_n  = work;
        dvs_n   = dvs;
        quot_n  = quot;
        rem_n   = rem;
        busy_n  = 1'b0;
        done_n  = 1'b0;
`ifdef DIVIDER_DBZ_EN
        dbz_n   = dbz;
`endif
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    dvs_n  = bus.divisor;
                    work_n = bus.dividend;
                    acc_n  = '0;
                    cnt_n  = CW'(WIDTH);
`ifdef DIVIDER_DBZ_EN
                    dbz_n  = (bus.divisor == '0);
                    if (bus.divisor == '0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        quot_n  = '1;
                        rem_n   = bus.dividend;
                    end else begin
                        state_n = RUN;
                        busy_n  = 1'b1;
                    end
`else
                    state_n = RUN;
                    busy_n  = 1'b1;
`endif
                end else if (state == DONE) begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                acc_n  = borrow_c ? shifted_c : trial_c;
                work_n = {work[WIDTH-2:0], ~borrow_c};
                cnt_n  = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    quot_n  = work_n;
                    rem_n   = acc_n[WIDTH-1:0];
                end else begin
                    busy_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            work  <= '0;
            dvs   <= '0;
            quot  <= '0;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DIVIDER_DBZ_EN
            dbz   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
            work  <= work_n;
            dvs   <= dvs_n;
            quot  <= quot_n;
            rem   <= rem_n;
            busy  <= busy_n;
            done  <= done_n;
`ifdef DIVIDER_DBZ_EN
            dbz   <= dbz_n;
`endif
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.quotient  = quot;
    assign bus.remainder = rem;
`ifdef DIVIDER_DBZ_EN
    assign bus.div_by_zero = dbz;
`else
    assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed corner cases, reset abort,
// back-to-back starts and a random sweep against a plain-arithmetic model.
module tb_seq_restoring_divider;
    localparam int unsigned W        = 8;
    localparam int unsigned N_RANDOM = 3000;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called just after the accepting edge; returns edges until done is seen.
    task automatic wait_done(output int n, output int gaps);
        n    = 0;
        gaps = 0;
        while (!bus.done && n < int'(4 * W)) begin
            if (!bus.busy) gaps++;
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", 64'(bus.done), 64'd1);
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int lat, input int gaps);
        logic [W-1:0] eq, er;
        int           exp_lat;
        logic         exp_dbz;
        ref_div(a, b, eq, er);
        exp_lat = W;
        exp_dbz = 1'b0;
`ifdef DIVIDER_DBZ_EN
        if (b == 0) begin
            exp_lat = 0;
            exp_dbz = 1'b1;
        end
`endif
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_gaps"}, 64'(gaps), 64'd0);
        check({tag, "_quotient"}, 64'(bus.quotient), 64'(eq));
        check({tag, "_remainder"}, 64'(bus.remainder), 64'(er));
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int n, gaps;
        launch(a, b);
        wait_done(n, gaps);
        expect_result(tag, a, b, n, gaps);
    endtask

    initial begin
        int           n, gaps, spurious;
        logic [W-1:0] a, b;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_quotient", 64'(bus.quotient), 64'd0);
        check("rst_remainder", 64'(bus.remainder), 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        rst = 1'b0;

        run_op("d100_7", 8'd100, 8'd7);
        run_op("d255_1", 8'd255, 8'd1);
        run_op("d5_9", 8'd5, 8'd9);
        run_op("d0_13", 8'd0, 8'd13);
        run_op("d200_0", 8'd200, 8'd0);
        run_op("d255_255", 8'd255, 8'd255);
        run_op("d0_0", 8'd0, 8'd0);
        run_op("d1_255", 8'd1, 8'd255);

        // Reset during the 4th RUN cycle of 77/3 discards the operation.
        run_op("pre_rst", 8'd100, 8'd7);
        launch(8'd77, 8'd3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_quotient", 64'(bus.quotient), 64'd0);
        check("midrst_remainder", 64'(bus.remainder), 64'd0);
        check("midrst_dbz", 64'(bus.div_by_zero), 64'd0);
        spurious = 0;
        repeat (2 * W) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) spurious++;
        end
        check("midrst_no_done", 64'(spurious), 64'd0);
        run_op("post_rst", 8'd77, 8'd3);

        // Back-to-back: start held in the DONE cycle, then ignored while running.
        run_op("b2b_first", 8'd100, 8'd7);
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd6;
        @(posedge clk);
        #1;
        check("b2b_hold_quotient", 64'(bus.quotient), 64'd14);
        check("b2b_hold_remainder", 64'(bus.remainder), 64'd2);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        bus.dividend = 8'd200;
        bus.divisor  = 8'd3;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        wait_done(n, gaps);
        expect_result("b2b_second", 8'd50, 8'd6, n + 2, gaps);

        for (int i = 0; i < int'(N_RANDOM); i++) begin
            a = W'($urandom);
            if ($urandom_range(0, 15) == 0)
                b = '0;
            else if ($urandom_range(0, 3) == 0)
                b = W'($urandom_range(1, 15));
            else
                b = W'($urandom);
            run_op("rand", a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish expected finish, total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
